cache_set_controller: RTL
=========================

Name: cache_set_controller

Overview:
- Fully associative, NUM_WAYS-way cache set with integrated tag compare, true-LRU replacement, byte-enable writes, dirty-line write-back and a whole-set flush.
- Generalises the single-way storage/age-tracker block into a self-contained set with its own request FSM.
- Sits between the core-side request port and the memory-side fill/write-back ports.

Parameters:
- NUM_WAYS, 4, number of ways; power of two, at least 2.
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- BLOCK_SIZE, 32, line size in bytes; WORDS = BLOCK_SIZE/(DATA_WIDTH/8), a power of two.
- ADDRESS_WIDTH, 32, byte address width.
- Derived: BOFF = $clog2(DATA_WIDTH/8); WOFF = $clog2(WORDS); TAG = ADDRESS_WIDTH-WOFF-BOFF; LINE = WORDS*DATA_WIDTH.

Ports:
- clk  in  1  global clock.
- reset_n  in  1  global asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with flush_req low.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  request hit in LOOKUP.
- rsp_rdata  out  DATA_WIDTH  word after the operation is applied.
- wb_valid  out  1  write-back request.
- wb_ready  in  1  write-back accept.
- wb_addr  out  ADDRESS_WIDTH  line-aligned victim address.
- wb_line  out  LINE  victim line data.
- fill_req_valid  out  1  fill request.
- fill_req_ready  in  1  fill request accept.
- fill_addr  out  ADDRESS_WIDTH  line-aligned miss address.
- fill_valid  in  1  fill data present for one cycle.
- fill_line  in  LINE  fill data; word i at [i*DATA_WIDTH +: DATA_WIDTH].
- flush_req  in  1  request a write-back and invalidate of the whole set.
- flush_done  out  1  one-cycle pulse when the flush completes.

Behaviour:
- Reset (asynchronous, active-low, any state including mid-transaction):
  - State goes to IDLE. All valid and dirty bits clear. Data array clears to 0.
  - age[w] = w.
  - All outputs 0 except req_ready = 1.
- FSM states: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP, FLUSH.
- IDLE:
  - flush_req has priority: go to FLUSH with the way pointer at 0.
  - Otherwise, on req_valid && req_ready, register addr/wdata/be/write and go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit = any valid way whose tag equals req_addr[ADDRESS_WIDTH-1:WOFF+BOFF]. Multiple hits are illegal (assertion).
  - On hit: apply the operation to the hit way, touch it, go to RESP, rsp_hit = 1.
  - On miss, victim = lowest-index invalid way; if none, the way with age == NUM_WAYS-1.
  - Victim valid && dirty: go to WB. Otherwise go to FILL_REQ.
- WB:
  - wb_valid = 1; wb_addr = {victim tag, zeros}; wb_line = victim data.
  - All three held stable until the cycle wb_ready = 1, then go to FILL_REQ.
- FILL_REQ:
  - fill_req_valid = 1; fill_addr = req_addr with the low WOFF+BOFF bits zeroed.
  - Held until fill_req_ready, then go to FILL_WAIT.
- FILL_WAIT:
  - On fill_valid, install fill_line into the victim way with tag loaded, valid = 1, dirty = 0.
  - Apply the operation, touch the way, go to RESP with rsp_hit = 0.
  - fill_valid in any other state is ignored.
- Operation:
  - Read: rsp_rdata = word[addr[WOFF+BOFF-1:BOFF]].
  - Write: per-byte merge of req_wdata where req_be[b] = 1; set dirty = 1; rsp_rdata = merged word.
  - Write with be = 0: word unchanged but dirty still set.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- Hit latency: request handshake at cycle N, rsp_valid at cycle N+2.
- True LRU touch of way x with age A: age[x] <= 0; every way with age < A increments; others hold. Ages always remain a permutation of 0..NUM_WAYS-1.
- FLUSH:
  - For way pointer p = 0..NUM_WAYS-1 ascending: if valid && dirty, issue a WB handshake (same rules as WB).
  - Then clear valid[p] and dirty[p] and increment p.
  - After the last way, pulse flush_done for one cycle and return to IDLE.
  - Ages unchanged. req_ready = 0 throughout.
- flush_req held high while a request is in flight: serviced on the next IDLE cycle, never mid-request.

Test Plan:
(NUM_WAYS=4, DATA_WIDTH=32, BLOCK_SIZE=32, ADDRESS_WIDTH=32)
1. Cold read 0x0000_1004, fill_line word1 = 0xDEADBEEF -> fill_addr = 0x0000_1000, no wb_valid, rsp_hit = 0, rsp_rdata = 0xDEADBEEF, line installed in way 0.
2. Write 0x0000_1004, be = 4'b0011, data 0x12345678 -> rsp_valid 2 cycles after the handshake, rsp_hit = 1; a following read of 0x1004 returns 0xDEAD5678.
3. Fill 0x1000, 0x2000, 0x3000, 0x4000; read 0x1000; read 0x5000 -> the 0x2000 line is evicted; clean, so no wb_valid; a subsequent read of 0x2000 misses.
4. Dirty victim with wb_ready held 0 for 5 cycles -> wb_valid, wb_addr and wb_line stable for all 5 cycles; fill_req_valid rises only after the wb handshake.
5. Two dirty lines (ways 1 and 3), flush_req pulse -> exactly two wb transactions, way 1 then way 3; one flush_done pulse; a later read of any prior address misses.
6. reset_n asserted during FILL_WAIT, then a late fill_valid -> outputs reset, req_ready = 1 after release, late fill ignored, all ways invalid.

Source files
------------

// File: rtl/cache_set_controller.sv
// Fully associative cache set: tag compare, true-LRU replacement, byte-enable
// writes, dirty write-back and whole-set flush behind a single request FSM.
module cache_set_controller #(
    parameter int NUM_WAYS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_be,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ADDRESS_WIDTH-1:0]   wb_addr,
    output logic [BLOCK_SIZE*8-1:0]    wb_line,
    output logic                       fill_req_valid,
    input  logic                       fill_req_ready,
    output logic [ADDRESS_WIDTH-1:0]   fill_addr,
    input  logic                       fill_valid,
    input  logic [BLOCK_SIZE*8-1:0]    fill_line,
    input  logic                       flush_req,
    output logic                       flush_done
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = BLOCK_SIZE / BYTES;
    localparam int BOFF  = $clog2(BYTES);
    localparam int WOFF  = $clog2(WORDS);
    localparam int TAG   = ADDRESS_WIDTH - WOFF - BOFF;
    localparam int LINE  = WORDS * DATA_WIDTH;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP, FLUSH} state_t;

    state_t                    state;
    logic [NUM_WAYS-1:0]       valid_q;
    logic [NUM_WAYS-1:0]       dirty_q;
    logic [TAG-1:0]            tag_q   [NUM_WAYS];
    logic [LINE-1:0]           data_q  [NUM_WAYS];
    logic [WAY_W-1:0]          age_q   [NUM_WAYS];
    logic                      req_write_q;
    logic [ADDRESS_WIDTH-1:0]  req_addr_q;
    logic [DATA_WIDTH-1:0]     req_wdata_q;
    logic [BYTES-1:0]          req_be_q;
    logic [WAY_W-1:0]          victim_q;
    logic [WAY_W-1:0]          flush_ptr;
    logic                      flushing;

    logic [TAG-1:0]            req_tag;
    logic [WOFF-1:0]           word_sel;
    logic [NUM_WAYS-1:0]       hit_vec;
    logic                      hit_any;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          victim_way;
    logic [WAY_W-1:0]          op_way;
    logic [LINE-1:0]           base_line;
    logic [LINE-1:0]           new_line;
    logic [DATA_WIDTH-1:0]     old_word;
    logic [DATA_WIDTH-1:0]     new_word;
    logic [WAY_W-1:0]          age_next [NUM_WAYS];
    logic                      unused_byte_offset;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BYTES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    assign req_tag            = req_addr_q[ADDRESS_WIDTH-1 -: TAG];
    assign word_sel           = req_addr_q[WOFF+BOFF-1:BOFF];
    assign unused_byte_offset = ^req_addr_q[BOFF-1:0];
    assign req_ready          = (state == IDLE) && !flush_req;
    assign hit_any            = |hit_vec;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[w] && (tag_q[w] == req_tag);
        end
    end

    // Victim preference: lowest-index invalid way, else the least recently used.
    always_comb begin
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[w] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[w]) victim_way = WAY_W'(w);
        end
    end

    // The operation acts on the hit line in LOOKUP and on the incoming fill in FILL_WAIT.
    always_comb begin
        op_way    = (state == FILL_WAIT) ? victim_q : hit_way;
        base_line = (state == FILL_WAIT) ? fill_line : data_q[hit_way];
        old_word  = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (word_sel == WOFF'(i)) old_word = base_line[i*DATA_WIDTH +: DATA_WIDTH];
        end
        new_word = req_write_q ? merge_bytes(old_word, req_wdata_q, req_be_q) : old_word;
        new_line = base_line;
        for (int i = 0; i < WORDS; i++) begin
            if (word_sel == WOFF'(i)) new_line[i*DATA_WIDTH +: DATA_WIDTH] = new_word;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == op_way)             age_next[w] = '0;
            else if (age_q[w] < age_q[op_way])   age_next[w] = age_q[w] + 1'b1;
            else                                 age_next[w] = age_q[w];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            valid_q        <= '0;
            dirty_q        <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_q[w]  <= '0;
                data_q[w] <= '0;
                age_q[w]  <= WAY_W'(w);
            end
            req_write_q    <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_be_q       <= '0;
            victim_q       <= '0;
            flush_ptr      <= '0;
            flushing       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_rdata      <= '0;
            wb_valid       <= 1'b0;
            wb_addr        <= '0;
            wb_line        <= '0;
            fill_req_valid <= 1'b0;
            fill_addr      <= '0;
            flush_done     <= 1'b0;
        end else begin
            rsp_valid  <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        flush_ptr <= '0;
                        state     <= FLUSH;
                    end else if (req_valid) begin
                        req_write_q <= req_write;
                        req_addr_q  <= req_addr;
                        req_wdata_q <= req_wdata;
                        req_be_q    <= req_be;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_any) begin
                        data_q[op_way] <= new_line;
                        if (req_write_q) dirty_q[op_way] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= age_next[w];
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_rdata <= new_word;
                        state     <= RESP;
                    end else begin
                        victim_q <= victim_way;
                        if (valid_q[victim_way] && dirty_q[victim_way]) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= {tag_q[victim_way], {(WOFF+BOFF){1'b0}}};
                            wb_line  <= data_q[victim_way];
                            flushing <= 1'b0;
                            state    <= WB;
                        end else begin
                            fill_req_valid <= 1'b1;
                            fill_addr      <= {req_tag, {(WOFF+BOFF){1'b0}}};
                            state          <= FILL_REQ;
                        end
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (flushing) begin
                            dirty_q[flush_ptr] <= 1'b0;
                            state              <= FLUSH;
                        end else begin
                            fill_req_valid <= 1'b1;
                            fill_addr      <= {req_tag, {(WOFF+BOFF){1'b0}}};
                            state          <= FILL_REQ;
                        end
                    end
                end
                FILL_REQ: begin
                    if (fill_req_ready) begin
                        fill_req_valid <= 1'b0;
                        state          <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fill_valid) begin
                        data_q[victim_q]  <= new_line;
                        tag_q[victim_q]   <= req_tag;
                        valid_q[victim_q] <= 1'b1;
                        dirty_q[victim_q] <= req_write_q;
                        for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= age_next[w];
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_rdata <= new_word;
                        state     <= RESP;
                    end
                end
                RESP: state <= IDLE;
                // A dirty way first goes through WB, which clears its dirty bit and returns here.
                FLUSH: begin
                    if (valid_q[flush_ptr] && dirty_q[flush_ptr]) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= {tag_q[flush_ptr], {(WOFF+BOFF){1'b0}}};
                        wb_line  <= data_q[flush_ptr];
                        flushing <= 1'b1;
                        state    <= WB;
                    end else begin
                        valid_q[flush_ptr] <= 1'b0;
                        dirty_q[flush_ptr] <= 1'b0;
                        if (flush_ptr == WAY_W'(NUM_WAYS - 1)) begin
                            flush_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            flush_ptr <= flush_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
        (state == LOOKUP) |-> $onehot0(hit_vec));

endmodule
